cfg_chain_loader: RTL
=====================

# cfg_chain_loader

Sequencer that loads configuration bitstreams into the reconfigurable module's serial configuration chains (reconfiguration-signal register, bitdata register, TR-FSM chains). It accepts 16-bit words from a producer, such as a CPU peripheral FIFO or a DMA, and serialises them LSB-first into one selected chain. It drives the chain's mode, shift and clock-strobe lines and optionally collects the bits shifted out for readback. It sits between the peripheral bus side and the `CfgClk`/`CfgShift`/`CfgDataOut` fan-out of the reconfigurable logic.

## Interface
- `NumCfgs`, default 4: number of configuration chains.
- `SelWidth`, default 2: width of chain select; must satisfy 2^`SelWidth` ≥ `NumCfgs`.
- `CntWidth`, default 16: width of the bit counter.
- `Clk_i` in 1: single clock.
- `Reset_n_i` in 1: asynchronous, active-low reset.
- `Start_i` in 1: start request; sampled only in IDLE.
- `Abort_i` in 1: synchronous abort of a running load.
- `ChainSel_i` in `SelWidth`: target chain; latched on start.
- `BitCount_i` in `CntWidth`: chain length in bits; latched on start.
- `Word_i` in 16: bitstream word.
- `WordValid_i` in 1: `Word_i` valid.
- `WordReady_o` out 1: loader can accept a word.
- `Busy_o` out 1: load in progress.
- `Done_o` out 1: one-cycle pulse at load end.
- `Error_o` out 1: one-cycle pulse on bad select or abort; coincides with `Done_o` on abort.
- `CfgMode_o` out 1: chain configuration mode.
- `CfgClk_o` out `NumCfgs`: per-chain shift-clock strobe.
- `CfgShift_o` out `NumCfgs`: per-chain shift enable.
- `CfgDataOut_o` out 1: serial data to all chains.
- `CfgDataIn_i` in `NumCfgs`: serial data returned from the chains.
- `RdWord_o` out 16: readback word. Present only with the macro.
- `RdValid_o` out 1: readback word strobe. Present only with the macro.

## Operation
- States: IDLE, SETUP, WAIT_WORD, SHIFT_LO, SHIFT_HI, FINISH.
- **IDLE.** `Start_i`=1 latches `ChainSel_i` and `BitCount_i`.
  - Select ≥ `NumCfgs`: pulse `Error_o` and stay in IDLE.
  - `BitCount_i`=0: pulse `Done_o` and stay in IDLE. No chain activity.
  - Otherwise go to SETUP.
- **SETUP.** Asserts `CfgMode_o`=1 and `CfgShift_o[sel]`=1, then goes to WAIT_WORD.
- **WAIT_WORD.** `WordReady_o`=1. On `WordValid_i`&&`WordReady_o`, load the shift register with `Word_i`, set the word-bit index to 0, and go to SHIFT_LO.
- **SHIFT_LO.** `CfgDataOut_o` = current bit, with `CfgClk_o` all 0. Go to SHIFT_HI.
- **SHIFT_HI.** `CfgClk_o[sel]`=1 and data held; this is the chain's capture edge. Then decrement the remaining-bit count and:
  - remaining = 0: go to FINISH;
  - word-bit index = 15: go to WAIT_WORD;
  - otherwise: go to SHIFT_LO with the next bit.
- **FINISH.** `CfgShift_o`=0, `CfgMode_o` still 1. Pulse `Done_o` and go to IDLE.
- `CfgMode_o` drops to 0 on entry to IDLE.
- Bits of a final partial word above `BitCount` are discarded.
- Only chain `sel` ever sees `CfgClk_o`/`CfgShift_o` high.
- `Abort_i` in any state other than IDLE:
  - the next state is FINISH;
  - `Done_o` and `Error_o` pulse together;
  - no further `CfgClk_o` strobe occurs.
- `Start_i` outside IDLE is ignored.
- `Busy_o` = (state ≠ IDLE).

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE;
  - counters and shift register cleared.
- Reset mid-load returns everything to IDLE immediately. The chain contents are undefined afterwards.
- All outputs are registered.
- Cycle timing from a start in cycle 0:
  - SETUP in cycle 1;
  - WAIT_WORD in cycle 2.
- With a word available on every WAIT_WORD cycle, N bits take 2 + ceil(N/16) + 2N + 1 cycles to `Done_o`.
- `CfgDataOut_o` is stable for one cycle before and during each `CfgClk_o` strobe.
- A word is never accepted while the loader is in a SHIFT state.

## Configuration
- `CFG_LOADER_READBACK_EN` defined:
  - in SHIFT_HI, `CfgDataIn_i[sel]` shifts into `RdWord_o`, LSB-first;
  - `RdValid_o` pulses for one cycle after each 16th captured bit, and after the final bit with zero-filled upper bits;
  - readback is produced on abort as well.
- Undefined: the readback ports and logic are absent.

## Structure
- Package `cfg_loader_pkg`:
  - the state enum;
  - the word width constant (16);
  - the `Done_o`/`Error_o` encoding helpers.
- One sub-module, `cfg_bit_serializer`, covering the 16-bit shift register, the word-bit index and the LO/HI phase generation.
- The top level holds the FSM, the bit counter and the chain demux.

## Test plan
- Select chain 1, `BitCount`=9, one word 0x0155.
  - `CfgClk_o[1]` gives exactly 9 strobes carrying data bits 1,0,1,0,1,0,1,0,1.
  - `CfgClk_o[0,2,3]` stay 0.
  - `Done_o` pulses in cycle 21.
- `BitCount`=20 with words 0xFFFF and 0x000A, where `WordValid_i` is delayed 5 cycles before the second word.
  - 20 strobes occur, with a 5-cycle gap.
  - The last 4 bits are 0,1,0,1.
- `ChainSel_i`=5 with `NumCfgs`=4: `Error_o` pulses in cycle 1, `Busy_o` stays 0, and there is no `CfgMode_o`.
- `Abort_i` after 3 strobes: no 4th strobe occurs, `Done_o` and `Error_o` pulse together, then IDLE with `CfgMode_o`=0.
- `BitCount`=0: `Done_o` in cycle 1 and no `WordReady_o`.
- Readback: chain model returns 0xA5A5 during a 16-bit load, giving `RdWord_o`=0xA5A5 with a single `RdValid_o` pulse.
- Reset asserted mid-shift: outputs are 0 asynchronously, and the next start behaves normally.

Source files
------------

// File: rtl/cfg_chain_loader_pkg.sv
// Shared types for the configuration-chain loader: FSM states, word geometry
// and the Done/Error status encoding used by the top level.
package cfg_loader_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned IDX_W  = $clog2(WORD_W);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_WAIT_WORD = 3'd2,
    ST_SHIFT_LO  = 3'd3,
    ST_SHIFT_HI  = 3'd4,
    ST_FINISH    = 3'd5
  } state_e;

  typedef struct packed {
    logic done;
    logic error;
  } status_t;

  // A load ends (Done) on reaching FINISH or on a zero-length request;
  // Error flags a bad chain select or an abort, so an abort raises both.
  function automatic status_t status_enc(input logic finish, input logic zero_len,
                                         input logic bad_sel, input logic aborted);
    status_t s;
    s.done  = finish | zero_len;
    s.error = bad_sel | aborted;
    return s;
  endfunction

endpackage

// File: rtl/cfg_chain_loader_if.sv
// Bus between the word producer / chain fan-out and the loader.
// Readback signals exist only when CFG_LOADER_READBACK_EN is defined.
interface cfg_chain_loader_if #(
  parameter int NumCfgs  = 4,
  parameter int SelWidth = 2,
  parameter int CntWidth = 16
) ();

  logic                               Start_i;
  logic                               Abort_i;
  logic [SelWidth-1:0]                ChainSel_i;
  logic [CntWidth-1:0]                BitCount_i;
  logic [cfg_loader_pkg::WORD_W-1:0]  Word_i;
  logic                               WordValid_i;
  logic                               WordReady_o;
  logic                               Busy_o;
  logic                               Done_o;
  logic                               Error_o;
  logic                               CfgMode_o;
  logic [NumCfgs-1:0]                 CfgClk_o;
  logic [NumCfgs-1:0]                 CfgShift_o;
  logic                               CfgDataOut_o;
  logic [NumCfgs-1:0]                 CfgDataIn_i;
`ifdef CFG_LOADER_READBACK_EN
  logic [cfg_loader_pkg::WORD_W-1:0]  RdWord_o;
  logic                               RdValid_o;
`endif

  modport master (
`ifdef CFG_LOADER_READBACK_EN
    input  RdWord_o, RdValid_o,
`endif
    output Start_i, Abort_i, ChainSel_i, BitCount_i, Word_i, WordValid_i, CfgDataIn_i,
    input  WordReady_o, Busy_o, Done_o, Error_o, CfgMode_o, CfgClk_o, CfgShift_o,
           CfgDataOut_o
  );

  modport slave (
`ifdef CFG_LOADER_READBACK_EN
    output RdWord_o, RdValid_o,
`endif
    input  Start_i, Abort_i, ChainSel_i, BitCount_i, Word_i, WordValid_i, CfgDataIn_i,
    output WordReady_o, Busy_o, Done_o, Error_o, CfgMode_o, CfgClk_o, CfgShift_o,
           CfgDataOut_o
  );

endinterface

// File: rtl/cfg_chain_loader_bit_serializer.sv
// 16-bit LSB-first shift register with word-bit index; the current serial bit
// is the register's bit 0, so it stays stable across a LO/HI phase pair.
module cfg_bit_serializer
  import cfg_loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_clear,
  input  logic [WORD_W-1:0] i_word,
  output logic              o_bit,
  output logic              o_word_end
);

  logic [WORD_W-1:0] r_shift;
  logic [IDX_W-1:0]  r_idx;

  // Load on word accept, advance after each HI phase, clear when the load ends.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= {WORD_W{1'b0}};
      r_idx   <= {IDX_W{1'b0}};
    end else if (i_clear) begin
      r_shift <= {WORD_W{1'b0}};
      r_idx   <= {IDX_W{1'b0}};
    end else if (i_load) begin
      r_shift <= i_word;
      r_idx   <= {IDX_W{1'b0}};
    end else if (i_step) begin
      r_shift <= {1'b0, r_shift[WORD_W-1:1]};
      r_idx   <= r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
    end else begin
      r_shift <= r_shift;
      r_idx   <= r_idx;
    end
  end

  assign o_bit      = r_shift[0];
  assign o_word_end = (r_idx == {IDX_W{1'b1}});

endmodule

// File: rtl/cfg_chain_loader.sv
// Loads 16-bit words LSB-first into one selected serial configuration chain.
// Optional readback of the shifted-out bits with CFG_LOADER_READBACK_EN.
module cfg_chain_loader
  import cfg_loader_pkg::*;
#(
  parameter int NumCfgs  = 4,
  parameter int SelWidth = 2,
  parameter int CntWidth = 16
) (
  input logic               Clk_i,
  input logic               Reset_n_i,
  cfg_chain_loader_if.slave bus
);

  localparam logic [SelWidth:0]   SEL_LIMIT = (SelWidth+1)'(NumCfgs);
  localparam logic [CntWidth-1:0] CNT_ZERO  = {CntWidth{1'b0}};
  localparam logic [CntWidth-1:0] CNT_ONE   = CntWidth'(1);

  state_e              r_state, w_state_nxt;
  logic [SelWidth-1:0] r_sel, w_sel;
  logic [CntWidth-1:0] r_remaining;
  logic [NumCfgs-1:0]  w_onehot, r_cfg_clk, r_cfg_shift;
  logic                r_mode, r_busy, r_done, r_error, r_word_ready;
  logic                w_bad_sel, w_zero_len, w_abort_take, w_load, w_step, w_clear;
  logic                w_bit, w_word_end;
  status_t             w_status;

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_bad_sel    = 1'b0;
    w_zero_len   = 1'b0;
    w_abort_take = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.Start_i && ({1'b0, bus.ChainSel_i} >= SEL_LIMIT)) begin
          w_bad_sel = 1'b1;
        end else if (bus.Start_i && (bus.BitCount_i == CNT_ZERO)) begin
          w_zero_len = 1'b1;
        end else if (bus.Start_i) begin
          w_state_nxt = ST_SETUP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: w_state_nxt = ST_WAIT_WORD;
      ST_WAIT_WORD: begin
        if (bus.WordValid_i) w_state_nxt = ST_SHIFT_LO;
        else                 w_state_nxt = ST_WAIT_WORD;
      end
      ST_SHIFT_LO: w_state_nxt = ST_SHIFT_HI;
      ST_SHIFT_HI: begin
        if (r_remaining == CNT_ONE) w_state_nxt = ST_FINISH;
        else if (w_word_end)        w_state_nxt = ST_WAIT_WORD;
        else                        w_state_nxt = ST_SHIFT_LO;
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    // Abort overrides every active state; FINISH is already on its way out.
    if (bus.Abort_i && (r_state != ST_IDLE) && (r_state != ST_FINISH)) begin
      w_abort_take = 1'b1;
      w_state_nxt  = ST_FINISH;
    end else begin
      w_abort_take = 1'b0;
    end
  end

  assign w_load   = (r_state == ST_WAIT_WORD) && bus.WordValid_i;
  assign w_step   = (r_state == ST_SHIFT_HI);
  assign w_clear  = (r_state == ST_FINISH);
  assign w_sel    = (r_state == ST_IDLE) ? bus.ChainSel_i : r_sel;
  assign w_onehot = {{(NumCfgs-1){1'b0}}, 1'b1} << w_sel;
  assign w_status = status_enc(w_state_nxt == ST_FINISH, w_zero_len, w_bad_sel, w_abort_take);

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      r_sel       <= {SelWidth{1'b0}};
      r_remaining <= CNT_ZERO;
    end else if ((r_state == ST_IDLE) && bus.Start_i) begin
      r_sel       <= bus.ChainSel_i;
      r_remaining <= bus.BitCount_i;
    end else if (w_step) begin
      r_sel       <= r_sel;
      r_remaining <= r_remaining - CNT_ONE;
    end else begin
      r_sel       <= r_sel;
      r_remaining <= r_remaining;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      r_busy       <= 1'b0;
      r_mode       <= 1'b0;
      r_word_ready <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_cfg_clk    <= {NumCfgs{1'b0}};
      r_cfg_shift  <= {NumCfgs{1'b0}};
    end else begin
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_mode       <= (w_state_nxt != ST_IDLE);
      r_word_ready <= (w_state_nxt == ST_WAIT_WORD);
      r_done       <= w_status.done;
      r_error      <= w_status.error;
      r_cfg_clk    <= (w_state_nxt == ST_SHIFT_HI) ? w_onehot : {NumCfgs{1'b0}};
      r_cfg_shift  <= ((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_WAIT_WORD) ||
                       (w_state_nxt == ST_SHIFT_LO) || (w_state_nxt == ST_SHIFT_HI))
                      ? w_onehot : {NumCfgs{1'b0}};
    end
  end

  cfg_bit_serializer u_serializer (
    .i_clk      (Clk_i),
    .i_rst_n    (Reset_n_i),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_clear    (w_clear),
    .i_word     (bus.Word_i),
    .o_bit      (w_bit),
    .o_word_end (w_word_end)
  );

  assign bus.WordReady_o  = r_word_ready;
  assign bus.Busy_o       = r_busy;
  assign bus.Done_o       = r_done;
  assign bus.Error_o      = r_error;
  assign bus.CfgMode_o    = r_mode;
  assign bus.CfgClk_o     = r_cfg_clk;
  assign bus.CfgShift_o   = r_cfg_shift;
  assign bus.CfgDataOut_o = w_bit;

`ifdef CFG_LOADER_READBACK_EN
  logic [WORD_W-1:0] r_rd_acc, r_rd_word, w_rd_acc_nxt;
  logic [IDX_W:0]    r_rd_cnt, w_rd_cnt_nxt;
  logic              r_rd_valid, w_rd_emit, w_cap_bit;

  // The shift enable is one-hot on the active chain during HI, so it selects the return bit.
  always_comb begin
    w_cap_bit    = |(bus.CfgDataIn_i & r_cfg_shift);
    w_rd_acc_nxt = r_rd_acc;
    w_rd_cnt_nxt = r_rd_cnt;
    if (r_state == ST_SHIFT_HI) begin
      w_rd_acc_nxt = r_rd_acc | ({{(WORD_W-1){1'b0}}, w_cap_bit} << r_rd_cnt[IDX_W-1:0]);
      w_rd_cnt_nxt = r_rd_cnt + (IDX_W+1)'(1);
    end else begin
      w_rd_acc_nxt = r_rd_acc;
      w_rd_cnt_nxt = r_rd_cnt;
    end
    w_rd_emit = (w_rd_cnt_nxt == (IDX_W+1)'(WORD_W)) ||
                ((r_state == ST_SHIFT_HI) && (r_remaining == CNT_ONE)) ||
                (w_abort_take && (w_rd_cnt_nxt != {(IDX_W+1){1'b0}}));
  end

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      r_rd_acc   <= {WORD_W{1'b0}};
      r_rd_cnt   <= {(IDX_W+1){1'b0}};
      r_rd_word  <= {WORD_W{1'b0}};
      r_rd_valid <= 1'b0;
    end else if (w_rd_emit) begin
      r_rd_acc   <= {WORD_W{1'b0}};
      r_rd_cnt   <= {(IDX_W+1){1'b0}};
      r_rd_word  <= w_rd_acc_nxt;
      r_rd_valid <= 1'b1;
    end else begin
      r_rd_acc   <= w_rd_acc_nxt;
      r_rd_cnt   <= w_rd_cnt_nxt;
      r_rd_word  <= r_rd_word;
      r_rd_valid <= 1'b0;
    end
  end

  assign bus.RdWord_o  = r_rd_word;
  assign bus.RdValid_o = r_rd_valid;
`else
  logic w_unused_din;
  assign w_unused_din = ^bus.CfgDataIn_i;
`endif

endmodule
